mem_bus_arb: RTL and testbench

Two-requester arbiter that shares one single-outstanding memory-bus slave port (CLINT or external bridge) between master 0 (mem stage) and master 1 (secondary requester, e.g. fetch/debug). It uses registered round-robin grant with a per-transaction lock. A watchdog terminates stalled slaves with an error response. It sits between the pipeline's memory requesters and the peripheral decode.

---
 rtl/mem_bus_arb_pkg.sv | 18 +
 rtl/mem_bus_arb_if.sv | 24 ++
 rtl/mem_bus_arb_rr_arb2.sv | 11 +
 rtl/mem_bus_arb.sv | 109 ++++++++++
 tb/tb_mem_bus_arb.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings for the two-master memory-bus arbiter.
package mem_bus_arb_pkg;

  localparam int DATA_BUS      = 64;
  localparam int DATA_ADDR_BUS = 64;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arb_if.sv
// One single-outstanding memory-bus channel: request from master, completion from slave.
interface mem_bus_arb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              valid;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [DATA_W-1:0] data_write;
  logic              ready;
  logic [DATA_W-1:0] data_read;
  logic [1:0]        resp;

  modport master (
    output valid, req, addr, size, data_write,
    input  ready, data_read, resp
  );

  modport slave (
    input  valid, req, addr, size, data_write,
    output ready, data_read, resp
  );
endinterface

// File: rtl/mem_bus_arb_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module mem_bus_arb_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = valid;
    if (valid == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_bus_arb.sv
// Shares one single-outstanding slave port between m0 and m1 with a registered
// round-robin grant held for the whole transaction, plus a ready watchdog.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arb_if.slave       m0,
  mem_bus_arb_if.slave       m1,
  mem_bus_arb_if.master      s,
  output logic [1:0]         grant_o
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  pick;
  logic        gnt_valid, done, timeout_hit;

  mem_bus_arb_rr_arb2 u_rr_arb2 (
    .valid ({m1.valid, m0.valid}),
    .last  (last_q),
    .gnt   (pick)
  );

  assign grant_o     = grant_q;
  assign gnt_valid   = (grant_q[0] & m0.valid) | (grant_q[1] & m1.valid);
  assign done        = (state_q == BUSY) && gnt_valid && s.ready;
  assign timeout_hit = (state_q == BUSY) && gnt_valid && !s.ready && (wait_q == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wait_d  = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
      if (|pick) begin
        grant_d = pick;
        state_d = BUSY;
      end
    end else if (!gnt_valid) begin
      // owner abandoned its request: release without a completion or fairness update
      state_d = IDLE;
      grant_d = 2'b00;
    end else if (done || timeout_hit) begin
      state_d = IDLE;
      grant_d = 2'b00;
      last_d  = grant_q[1];
    end else begin
      wait_d = wait_q + 16'd1;
    end
  end

  // Request path is a pure mux on the registered grant; nothing reaches the slave in IDLE.
  always_comb begin
    s.valid      = gnt_valid & ~timeout_hit;
    s.req        = REQ_READ;
    s.addr       = '0;
    s.size       = 2'b00;
    s.data_write = '0;
    if (grant_q[0]) begin
      s.req        = m0.req;
      s.addr       = m0.addr;
      s.size       = m0.size;
      s.data_write = m0.data_write;
    end else if (grant_q[1]) begin
      s.req        = m1.req;
      s.addr       = m1.addr;
      s.size       = m1.size;
      s.data_write = m1.data_write;
    end
  end

  always_comb begin
    m0.ready     = grant_q[0] & (done | timeout_hit);
    m1.ready     = grant_q[1] & (done | timeout_hit);
    m0.data_read = (grant_q[0] & done) ? s.data_read : '0;
    m1.data_read = (grant_q[1] & done) ? s.data_read : '0;
    m0.resp      = RESP_OKAY;
    m1.resp      = RESP_OKAY;
    if (grant_q[0] & done)        m0.resp = s.resp;
    if (grant_q[1] & done)        m1.resp = s.resp;
    if (grant_q[0] & timeout_hit) m0.resp = RESP_SLVERR;
    if (grant_q[1] & timeout_hit) m1.resp = RESP_SLVERR;
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed vector bench for mem_bus_arb (TIMEOUT=4).
module tb_mem_bus_arb;

  localparam logic [63:0] M0_ADDR = 64'h0200_BFF8;
  localparam logic [63:0] M1_ADDR = 64'h0200_4000;
  localparam logic [63:0] M0_WD   = 64'h1111;
  localparam logic [63:0] M1_WD   = 64'hDEAD;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  mem_bus_arb_if #(.DATA_W(64), .ADDR_W(64)) m0_if ();
  mem_bus_arb_if #(.DATA_W(64), .ADDR_W(64)) m1_if ();
  mem_bus_arb_if #(.DATA_W(64), .ADDR_W(64)) s_if ();

  mem_bus_arb #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .s       (s_if.master),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0v, m1v, srdy;
    logic [15:0] sdata;
    logic [1:0]  sresp;
    logic        svalid;
    logic [1:0]  gnt;
    logic        r0, r1;
    logic [15:0] d0, d1;
    logic [1:0]  rs0, rs1;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic m0v, logic m1v, logic srdy, logic [15:0] sdata,
                              logic [1:0] sresp, logic svalid, logic [1:0] gnt,
                              logic r0, logic r1, logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] rs0, logic [1:0] rs1);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.srdy = srdy; v.sdata = sdata; v.sresp = sresp;
    v.svalid = svalid; v.gnt = gnt; v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.d1 = d1; v.rs0 = rs0; v.rs1 = rs1;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic m0v, logic m1v, logic srdy, logic [15:0] sdata, logic [1:0] sresp);
    m0_if.valid     = m0v;
    m1_if.valid     = m1v;
    s_if.ready      = srdy;
    s_if.data_read  = {48'h0, sdata};
    s_if.resp       = sresp;
  endtask

  task automatic apply(int i, vec_t v);
    logic [63:0] ea, ew, eq, es;
    drive(v.m0v, v.m1v, v.srdy, v.sdata, v.sresp);
    ea = '0; ew = '0; eq = '0; es = '0;
    if (v.gnt == 2'b01) begin ea = M0_ADDR; ew = M0_WD; eq = 64'd0; es = 64'd3; end
    if (v.gnt == 2'b10) begin ea = M1_ADDR; ew = M1_WD; eq = 64'd1; es = 64'd2; end
    @(negedge clk);
    chk($sformatf("v%0d_grant", i),  64'(grant),            64'(v.gnt));
    chk($sformatf("v%0d_svalid", i), 64'(s_if.valid),       64'(v.svalid));
    chk($sformatf("v%0d_saddr", i),  s_if.addr,             ea);
    chk($sformatf("v%0d_swdata", i), s_if.data_write,       ew);
    chk($sformatf("v%0d_sreq", i),   64'(s_if.req),         eq);
    chk($sformatf("v%0d_ssize", i),  64'(s_if.size),        es);
    chk($sformatf("v%0d_m0rdy", i),  64'(m0_if.ready),      64'(v.r0));
    chk($sformatf("v%0d_m1rdy", i),  64'(m1_if.ready),      64'(v.r1));
    chk($sformatf("v%0d_m0data", i), m0_if.data_read,       64'(v.d0));
    chk($sformatf("v%0d_m1data", i), m1_if.data_read,       64'(v.d1));
    chk($sformatf("v%0d_m0resp", i), 64'(m0_if.resp),       64'(v.rs0));
    chk($sformatf("v%0d_m1resp", i), 64'(m1_if.resp),       64'(v.rs1));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_if.req = 1'b0; m0_if.addr = M0_ADDR; m0_if.size = 2'd3; m0_if.data_write = M0_WD;
    m1_if.req = 1'b1; m1_if.addr = M1_ADDR; m1_if.size = 2'd2; m1_if.data_write = M1_WD;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 2'b00);

    // single m0 read
    vecs.push_back(mk(1,0,1,16'h1234,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,0,1,16'h1234,2'b00, 1,2'b01,1,0,16'h1234,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,0,1,16'h1234,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    // both valid continuously: alternating grants (m0 served last, so m1 first)
    vecs.push_back(mk(1,1,1,16'h00A1,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,1,1,16'h00A1,2'b00, 1,2'b10,0,1,16'h0,16'h00A1,2'b00,2'b00));
    vecs.push_back(mk(1,1,1,16'h00A2,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,1,1,16'h00A2,2'b00, 1,2'b01,1,0,16'h00A2,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,1,1,16'h00A3,2'b01, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,1,1,16'h00A3,2'b01, 1,2'b10,0,1,16'h0,16'h00A3,2'b00,2'b01));
    vecs.push_back(mk(0,0,1,16'h0,2'b00,    0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    // m1 write, slave ready after 3 wait cycles
    vecs.push_back(mk(0,1,0,16'h0055,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,0,16'h0055,2'b00, 1,2'b10,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,0,16'h0055,2'b00, 1,2'b10,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,0,16'h0055,2'b00, 1,2'b10,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,1,16'h0055,2'b00, 1,2'b10,0,1,16'h0,16'h0055,2'b00,2'b00));
    vecs.push_back(mk(0,0,0,16'h0,2'b00,    0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    // m0 timeout: slave never ready, error completion in BUSY cycle 5
    vecs.push_back(mk(1,0,0,16'hFFFF,2'b01, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,0,16'hFFFF,2'b01, 1,2'b01,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,0,0,16'hFFFF,2'b01, 0,2'b01,1,0,16'h0,16'h0,2'b10,2'b00));
    vecs.push_back(mk(0,0,0,16'h0,2'b00,    0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    // granted m0 drops valid; pending m1 gets the next grant
    vecs.push_back(mk(1,0,0,16'h0,2'b00,    0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,0,16'h0,2'b00,    0,2'b01,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,1,16'h0077,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,1,1,16'h0077,2'b00, 1,2'b10,0,1,16'h0,16'h0077,2'b00,2'b00));
    // m0 served last, so without a reset m1 would win the next tie
    vecs.push_back(mk(1,0,1,16'h0088,2'b00, 0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));
    vecs.push_back(mk(1,0,1,16'h0088,2'b00, 1,2'b01,1,0,16'h0088,16'h0,2'b00,2'b00));
    vecs.push_back(mk(0,0,1,16'h0,2'b00,    0,2'b00,0,0,16'h0,16'h0,2'b00,2'b00));

    #12;
    chk("rst_grant",  64'(grant),       64'd0);
    chk("rst_svalid", 64'(s_if.valid),  64'd0);
    chk("rst_m0rdy",  64'(m0_if.ready), 64'd0);
    chk("rst_m1rdy",  64'(m1_if.ready), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // async reset in the middle of a BUSY transaction
    drive(1'b1, 1'b1, 1'b0, 16'h0099, 2'b00);
    @(posedge clk); #1;
    chk("mid_busy_grant", 64'(grant), 64'd2);
    #1 rst = 1'b0;
    #1;
    chk("arst_grant",  64'(grant),       64'd0);
    chk("arst_svalid", 64'(s_if.valid),  64'd0);
    chk("arst_saddr",  s_if.addr,        64'd0);
    chk("arst_m1rdy",  64'(m1_if.ready), 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_grant", 64'(grant), 64'd0);
    #2 rst = 1'b1;
    s_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tie_grant", 64'(grant),       64'd1);
    chk("post_rst_m0rdy",     64'(m0_if.ready), 64'd1);
    chk("post_rst_m1rdy",     64'(m1_if.ready), 64'd0);
    chk("post_rst_m0data",    m0_if.data_read,  64'h0099);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
